// File: rtl/decodec_code_gen_pkg.sv
// Shared definitions for the code generator and its key filters.
// Code width must match the select input of decodec_3_8.
package decodec_code_gen_pkg;

  localparam int CODE_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILT_DN = 2'd1,
    DOWN    = 2'd2,
    FILT_UP = 2'd3
  } deb_state_t;

endpackage

// File: rtl/key_filter.sv
// Debounces one active-low key and emits a 1-clock pulse per accepted press.
// Latency: pulse DEB_CNT+3 clocks after the raw falling edge (2 sync + DEB_CNT+1 filter).
// Backpressure: none; the key is sampled every clock.
module key_filter #(
  parameter int DEB_CNT = 999_999
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic key_n,
  output logic key_press
);
  import decodec_code_gen_pkg::*;

  localparam int DW = (DEB_CNT > 0) ? $clog2(DEB_CNT + 1) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CNT);

  logic          key_s1;
  logic          key_s2;
  deb_state_t    state;
  logic [DW-1:0] cnt;

  // The transition edge into a filter state is itself the first stable sample,
  // so the count resumes at 1 and the level is held DEB_CNT+1 samples in total.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      key_s1    <= 1'b1;
      key_s2    <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      key_press <= 1'b0;
    end else begin
      key_s1    <= key_n;
      key_s2    <= key_s1;
      key_press <= 1'b0;
      case (state)
        IDLE: begin
          if (!key_s2) begin
            if (DEB_CNT == 0) begin
              state     <= DOWN;
              key_press <= 1'b1;
            end else begin
              state <= FILT_DN;
              cnt   <= DW'(1);
            end
          end
        end
        FILT_DN: begin
          if (key_s2) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state     <= DOWN;
            cnt       <= '0;
            key_press <= 1'b1;
          end else begin
            cnt <= cnt + DW'(1);
          end
        end
        DOWN: begin
          if (key_s2) begin
            if (DEB_CNT == 0) begin
              state <= IDLE;
            end else begin
              state <= FILT_UP;
              cnt   <= DW'(1);
            end
          end
        end
        FILT_UP: begin
          if (!key_s2) begin
            state <= DOWN;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + DW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/decodec_code_gen.sv
// Steps a 3-bit select code for decodec_3_8 every CNT_MAX+1 clocks, up or down, with run/pause keys.
// Latency: code and step_pulse registered; key presses act one clock after their filter pulse.
// Backpressure: none; outputs are free-running levels.
module decodec_code_gen #(
  parameter int CNT_MAX = 24_999_999,
  parameter int DEB_CNT = 999_999
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic key_run_n,
  input  logic key_dir_n,
  output logic a,
  output logic b,
  output logic c,
  output logic step_pulse,
  output logic running
);
  import decodec_code_gen_pkg::*;

  localparam int CW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX);

  logic              run_press;
  logic              dir_press;
  logic              dir_down;
  logic [CW-1:0]     cnt;
  logic [CODE_W-1:0] code;

  key_filter #(.DEB_CNT(DEB_CNT)) u_run (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .key_n     (key_run_n),
    .key_press (run_press)
  );

  key_filter #(.DEB_CNT(DEB_CNT)) u_dir (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .key_n     (key_dir_n),
    .key_press (dir_press)
  );

  // Step decisions use the pre-edge running/dir, so a coincident press
  // never cancels or redirects the step already due on this edge.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      running    <= 1'b1;
      dir_down   <= 1'b0;
      cnt        <= '0;
      code       <= '0;
      step_pulse <= 1'b0;
    end else begin
      if (run_press) running  <= ~running;
      if (dir_press) dir_down <= ~dir_down;
      if (running) begin
        if (cnt == CNT_LAST) begin
          cnt        <= '0;
          code       <= dir_down ? code - CODE_W'(1) : code + CODE_W'(1);
          step_pulse <= 1'b1;
        end else begin
          cnt        <= cnt + CW'(1);
          step_pulse <= 1'b0;
        end
      end else begin
        cnt        <= '0;
        step_pulse <= 1'b0;
      end
    end
  end

  assign {a, b, c} = code;

endmodule

// File: tb/tb_decodec_code_gen.sv
// Directed bench for decodec_code_gen with CNT_MAX=9, DEB_CNT=4.
// Expected codes are queued ahead of each step and popped when step_pulse is seen.
module tb_decodec_code_gen;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  logic key_run_n = 1'b1;
  logic key_dir_n = 1'b1;
  logic a, b, c, step_pulse, running;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [2:0] exp_q[$];
  logic [2:0] exp_code;
  int step_t[$];
  int seen = 0;
  int ref_cyc = 0;
  int run_press_cnt = 0, dir_press_cnt = 0;
  int run_press_cyc = -1, dir_press_cyc = -1;
  logic prev_sp = 1'b0;

  decodec_code_gen #(.CNT_MAX(9), .DEB_CNT(4)) u_dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .key_run_n  (key_run_n),
    .key_dir_n  (key_dir_n),
    .a          (a),
    .b          (b),
    .c          (c),
    .step_pulse (step_pulse),
    .running    (running)
  );

  always #5 Clk = ~Clk;

  initial forever begin
    @(posedge Clk);
    cyc++;
  end

  // Scoreboard side: every step pops one expected code.
  initial forever begin
    @(negedge Clk);
    if (Rst_n && step_pulse) begin
      step_t.push_back(cyc);
      checks++;
      assert (prev_sp === 1'b0) else begin
        errors++;
        $error("FAIL step_width obs=%0b exp=0", prev_sp);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL unexpected_step obs=%0d exp=none", {a, b, c});
      end else begin
        exp_code = exp_q.pop_front();
        assert ({a, b, c} === exp_code) else begin
          errors++;
          $error("FAIL step_code obs=%0d exp=%0d", {a, b, c}, exp_code);
        end
      end
    end
    if (Rst_n && u_dut.u_run.key_press) begin
      run_press_cnt++;
      run_press_cyc = cyc;
    end
    if (Rst_n && u_dut.u_dir.key_press) begin
      dir_press_cnt++;
      dir_press_cyc = cyc;
    end
    prev_sp = step_pulse;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  task automatic hold_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_step(input int gap, input string tag);
    int tgt;
    int k;
    tgt = seen + 1;
    k = 0;
    while (step_t.size() < tgt && k < 300) begin
      tick();
      k++;
    end
    if (step_t.size() < tgt) begin
      chk({tag, "_timeout"}, step_t.size(), tgt);
    end else begin
      chk(tag, step_t[tgt-1] - ref_cyc, gap);
      ref_cyc = step_t[tgt-1];
      seen = tgt;
    end
  endtask

  task automatic wait_press(input bit dir_key, input int base, input string tag);
    int k;
    k = 0;
    while (((dir_key ? dir_press_cnt : run_press_cnt) == base) && k < 30) begin
      tick();
      k++;
    end
    if (k == 30) chk({tag, "_timeout"}, (dir_key ? dir_press_cnt : run_press_cnt) - base, 1);
  endtask

  initial begin
    int d, s, base, n, k;

    // Reset state
    repeat (3) tick();
    chk("rst_code", int'({a, b, c}), 0);
    chk("rst_step_pulse", int'(step_pulse), 0);
    chk("rst_running", int'(running), 1);
    #2 Rst_n = 1'b1;
    ref_cyc = cyc;

    // Free run: 1..7, wrap to 0, then up to 3
    for (int i = 1; i <= 11; i++) exp_q.push_back(3'(i));
    for (int i = 0; i < 11; i++) wait_step(10, "t1_gap");
    chk("t1_running", int'(running), 1);

    // Direction press at code 3, counting down through the 0->7 wrap
    exp_q.push_back(3'd2); exp_q.push_back(3'd1);
    exp_q.push_back(3'd0); exp_q.push_back(3'd7);
    d = cyc;
    base = dir_press_cnt;
    key_dir_n = 1'b0;
    wait_press(1'b1, base, "t2_dir_press");
    chk("t2_dir_latency", dir_press_cyc - d, 7);
    hold_until(d + 20);
    key_dir_n = 1'b1;
    for (int i = 0; i < 4; i++) wait_step(10, "t2_gap");

    // Pause, freeze, resume
    d = cyc;
    base = run_press_cnt;
    key_run_n = 1'b0;
    wait_press(1'b0, base, "t3_run_press");
    chk("t3_run_latency", run_press_cyc - d, 7);
    tick();
    chk("t3_paused", int'(running), 0);
    hold_until(d + 10);
    key_run_n = 1'b1;
    n = step_t.size();
    hold_until(cyc + 50);
    chk("t3_no_step", step_t.size(), n);
    chk("t3_frozen_code", int'({a, b, c}), 7);
    exp_q.push_back(3'd6);
    d = cyc;
    key_run_n = 1'b0;
    k = 0;
    while (!running && k < 30) begin
      tick();
      k++;
    end
    chk("t3_resume_latency", cyc - d, 8);
    ref_cyc = cyc;
    hold_until(d + 10);
    key_run_n = 1'b1;
    wait_step(10, "t3_restart_gap");

    // Glitches rejected, then a clean hold toggles once
    exp_q.push_back(3'd5); exp_q.push_back(3'd4);
    base = run_press_cnt;
    key_run_n = 1'b0; repeat (3) tick();
    key_run_n = 1'b1; repeat (2) tick();
    key_run_n = 1'b0; repeat (3) tick();
    key_run_n = 1'b1; repeat (10) tick();
    chk("t4_glitch_press", run_press_cnt - base, 0);
    chk("t4_glitch_running", int'(running), 1);
    d = cyc;
    key_run_n = 1'b0;
    hold_until(d + 20);
    key_run_n = 1'b1;
    chk("t4_hold_press", run_press_cnt - base, 1);
    chk("t4_hold_running", int'(running), 0);
    wait_step(10, "t4_gap");
    wait_step(10, "t4_gap");
    repeat (10) tick();

    // Both keys at once: resume and flip to up
    exp_q.push_back(3'd5);
    d = cyc;
    key_run_n = 1'b0;
    key_dir_n = 1'b0;
    hold_until(d + 10);
    key_run_n = 1'b1;
    key_dir_n = 1'b1;
    chk("t5_both_run_lat", run_press_cyc - d, 7);
    chk("t5_both_dir_lat", dir_press_cyc - d, 7);
    chk("t5_both_running", int'(running), 1);
    ref_cyc = d + 8;
    wait_step(10, "t5_resume_gap");

    // Dir press coincident with the terminal count: old dir for this step
    s = step_t[seen-1];
    exp_q.push_back(3'd6); exp_q.push_back(3'd5);
    hold_until(s + 2);
    key_dir_n = 1'b0;
    hold_until(s + 12);
    key_dir_n = 1'b1;
    chk("t5_dir_align", dir_press_cyc, s + 9);
    wait_step(10, "t5_dir_gap");
    wait_step(10, "t5_dir_gap");

    // Run press coincident with the terminal count: step taken, then pause
    s = step_t[seen-1];
    exp_q.push_back(3'd4);
    hold_until(s + 2);
    key_run_n = 1'b0;
    hold_until(s + 12);
    key_run_n = 1'b1;
    chk("t5_run_align", run_press_cyc, s + 9);
    wait_step(10, "t5_run_gap");
    n = step_t.size();
    hold_until(s + 45);
    chk("t5_paused", int'(running), 0);
    chk("t5_no_step", step_t.size(), n);
    chk("t5_code", int'({a, b, c}), 4);

    // Reach code 6 going up, then reset mid-count
    exp_q.push_back(3'd5); exp_q.push_back(3'd6);
    d = cyc;
    key_run_n = 1'b0;
    key_dir_n = 1'b0;
    hold_until(d + 10);
    key_run_n = 1'b1;
    key_dir_n = 1'b1;
    ref_cyc = d + 8;
    wait_step(10, "t6_pre_gap");
    wait_step(10, "t6_pre_gap");
    s = step_t[seen-1];
    hold_until(s + 4);
    chk("t6_queue_drained", exp_q.size(), 0);
    #2 Rst_n = 1'b0;
    #1;
    chk("t6_rst_code", int'({a, b, c}), 0);
    chk("t6_rst_running", int'(running), 1);
    chk("t6_rst_step_pulse", int'(step_pulse), 0);
    repeat (3) tick();
    #2 Rst_n = 1'b1;
    ref_cyc = cyc;
    exp_q.push_back(3'd1); exp_q.push_back(3'd2);
    wait_step(10, "t6_post_gap");
    wait_step(10, "t6_post_gap");
    chk("end_queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
